// File: rtl/switch_led_top.sv
// Four independent push-switch channels. Each channel has a 2-flop synchronizer,
// a stability-counter debouncer, and a press detector that toggles its LED.
module switch_led_top #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_sw_n,
  output logic       o_led_blue,
  output logic       o_led_green,
  output logic       o_led_orange,
  output logic       o_led_red
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       s1_q, s2_q;
  logic [3:0]       db_q, db_d;
  logic [3:0]       led_q, led_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Plain two-flop synchronizer; reset to the released level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= i_sw_n;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    db_d  = db_q;
    led_d = led_q;
    for (int ch = 0; ch < 4; ch++) begin
      cnt_d[ch] = cnt_q[ch];
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (s2_q[ch] == db_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        db_d[ch]  = s2_q[ch];
        cnt_d[ch] = '0;
        // A press is the debounced level falling from released to pressed.
        if (db_q[ch]) begin
          led_d[ch] = ~led_q[ch];
        end
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      db_q  <= 4'hF;
      led_q <= 4'h0;
      for (int ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      db_q  <= db_d;
      led_q <= led_d;
      for (int ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign o_led_blue   = led_q[0];
  assign o_led_green  = led_q[1];
  assign o_led_orange = led_q[2];
  assign o_led_red    = led_q[3];

endmodule

// File: tb/tb_switch_led_top.sv
// Bench for switch_led_top: directed scenarios plus randomized switch activity,
// every cycle checked against a sliding-window reference of the debounce rules.
module tb_switch_led_top;

  localparam int D = 4;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_sw_n;
  logic       o_led_blue, o_led_green, o_led_orange, o_led_red;

  int compared;
  int mismatched;

  // Reference model: history of sampled switch vectors, debounced levels, LEDs.
  logic [3:0] hist[$];
  logic [3:0] m_db;
  logic [3:0] m_led;

  switch_led_top dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sw_n       (i_sw_n),
    .o_led_blue   (o_led_blue),
    .o_led_green  (o_led_green),
    .o_led_orange (o_led_orange),
    .o_led_red    (o_led_red)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [3:0] leds();
    return {o_led_red, o_led_orange, o_led_green, o_led_blue};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    // Both synchronizer stages come out of reset at the released level.
    hist.push_back(4'hF);
    hist.push_back(4'hF);
    m_db  = 4'hF;
    m_led = 4'h0;
  endtask

  // A channel's debounced level flips once the synchronized level (the input
  // sampled two edges earlier) has disagreed with it for D edges in a row.
  task automatic model_edge(input logic [3:0] sw);
    logic [3:0] new_db;
    logic       all_diff;
    hist.push_back(sw);
    new_db = m_db;
    if (hist.size() >= D + 2) begin
      for (int ch = 0; ch < 4; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (hist[hist.size() - 3 - j][ch] == m_db[ch]) all_diff = 1'b0;
        end
        if (all_diff) begin
          new_db[ch] = ~m_db[ch];
          if (m_db[ch]) m_led[ch] = ~m_led[ch];
        end
      end
    end
    m_db = new_db;
    while (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  // Driver tasks
  task automatic cycle(input logic [3:0] sw);
    i_sw_n = sw;
    @(posedge i_clk);
    model_edge(sw);
    #1;
    chk("led_model", leds(), m_led);
  endtask

  task automatic drive(input logic [3:0] sw, input int n);
    for (int i = 0; i < n; i++) cycle(sw);
  endtask

  // Asserts reset between edges, checks the LEDs clear before any clock edge,
  // then releases reset between edges too.
  task automatic apply_reset(input logic [3:0] sw);
    @(negedge i_clk);
    #2;
    i_sw_n = sw;
    i_rst  = 1'b1;
    #1;
    chk("async_reset", leds(), 4'h0);
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("reset_hold", leds(), 4'h0);
    i_rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rv;
    int         run;
    compared   = 0;
    mismatched = 0;
    i_rst      = 1'b1;
    i_sw_n     = 4'hF;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_state", leds(), 4'h0);
    @(negedge i_clk);
    i_rst = 1'b0;

    drive(4'hF, 20);
    chk("idle_after_reset", leds(), 4'h0);

    // Single press on sw0: toggle on the 6th edge counting the first low sample.
    drive(4'hE, 5);
    chk("blue_before_latency", leds(), 4'h0);
    drive(4'hE, 1);
    chk("blue_at_latency", leds(), 4'h1);
    drive(4'hE, 4);
    drive(4'hF, 10);
    chk("blue_after_release", leds(), 4'h1);

    drive(4'hE, 10);
    drive(4'hF, 10);
    chk("blue_second_press", leds(), 4'h0);

    // Sequential channels
    drive(4'hD, 10);
    drive(4'hF, 10);
    chk("green_press", leds(), 4'h2);
    drive(4'hB, 10);
    drive(4'hF, 10);
    chk("orange_press", leds(), 4'h6);
    drive(4'h7, 10);
    drive(4'hF, 10);
    chk("red_press", leds(), 4'hE);

    // Short glitch is rejected
    drive(4'hE, 2);
    drive(4'hF, 10);
    chk("glitch_rejected", leds(), 4'hE);

    // Bounce restarts the count; toggle 6th edge of the final low run
    drive(4'hE, 3);
    drive(4'hF, 1);
    drive(4'hE, 5);
    chk("bounce_before", leds(), 4'hE);
    drive(4'hE, 1);
    chk("bounce_accept", leds(), 4'hF);
    drive(4'hF, 10);

    // Reset with all LEDs lit
    apply_reset(4'hF);
    drive(4'hF, 5);
    chk("idle_after_midreset", leds(), 4'h0);

    // Simultaneous press: all four on the same edge
    drive(4'h0, 5);
    chk("simul_before", leds(), 4'h0);
    drive(4'h0, 1);
    chk("simul_accept", leds(), 4'hF);
    drive(4'h0, 4);
    drive(4'hF, 10);

    // sw2 held low through reset release: orange on edge 6 after release
    apply_reset(4'hB);
    drive(4'hB, 5);
    chk("held_before", leds(), 4'h0);
    drive(4'hB, 1);
    chk("held_accept", leds(), 4'h4);
    drive(4'hF, 10);

    // Randomized activity: random vectors held for random run lengths
    rv = 4'hF;
    for (int it = 0; it < 400; it++) begin
      rv  = 4'($urandom_range(0, 15));
      run = $urandom_range(1, 8);
      drive(rv, run);
      if (it == 200) begin
        apply_reset(4'($urandom_range(0, 15)));
      end
    end
    drive(4'hF, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
